// File: rtl/regf_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : regf_scoreboard_if
// Brief    : Issue / retire / flush / query bundle between the pipeline
//            (master: decode + writeback) and the register-file scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
interface regf_scoreboard_if #(
    parameter int NUM_REGS  = 32,
    parameter int REG_IDX_W = $clog2(NUM_REGS),
    parameter int MAX_PEND  = 3,
    parameter int NUM_SRC   = 2,
    parameter int CNT_W     = $clog2(MAX_PEND + 1),
    parameter int TOT_W     = $clog2(NUM_REGS * MAX_PEND + 1)
);
    // Issue side (decode)
    logic                           issue_valid;
    logic                           issue_regf_we;
    logic [REG_IDX_W-1:0]           issue_rd_s;
    logic                           issue_ready;

    // Retire side (writeback)
    logic                           retire_valid;
    logic [REG_IDX_W-1:0]           retire_rd_s;

    // Redirect
    logic                           flush;

    // Hazard query and status
    logic [NUM_SRC*REG_IDX_W-1:0]   src_s;
    logic [NUM_SRC-1:0]             src_busy;
    logic [NUM_REGS-1:0]            busy_vec;
    logic [TOT_W-1:0]               pending_total;
    logic                           underflow_err;

    modport master (
        output issue_valid, issue_regf_we, issue_rd_s,
        output retire_valid, retire_rd_s,
        output flush,
        output src_s,
        input  issue_ready, src_busy, busy_vec, pending_total, underflow_err
    );

    modport slave (
        input  issue_valid, issue_regf_we, issue_rd_s,
        input  retire_valid, retire_rd_s,
        input  flush,
        input  src_s,
        output issue_ready, src_busy, busy_vec, pending_total, underflow_err
    );
endinterface
`default_nettype wire

// File: rtl/regf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regf_scoreboard
// Brief    : Per-register outstanding-write counters for the RV32I pipeline.
//            Answers RAW hazard queries, back-pressures issue when a
//            register already has MAX_PEND writers in flight, retires on
//            writeback and clears everything on a redirect flush.
// Revision : 1.0 - initial release
// ============================================================================
module regf_scoreboard #(
    parameter int NUM_REGS  = 32,
    parameter int REG_IDX_W = $clog2(NUM_REGS),
    parameter int MAX_PEND  = 3,
    parameter int NUM_SRC   = 2,
    parameter int CNT_W     = $clog2(MAX_PEND + 1),
    parameter int TOT_W     = $clog2(NUM_REGS * MAX_PEND + 1)
) (
    input  wire             clk,
    input  wire             rst_n,
    regf_scoreboard_if.slave sb
);

    localparam logic [CNT_W-1:0]     C_MAX_PEND = CNT_W'(MAX_PEND);
    localparam logic [REG_IDX_W-1:0] C_X0       = '0;

    // Flat combinational view of all counters; entry 0 is the hardwired x0.
    logic [CNT_W-1:0]   w_cnt     [NUM_REGS];
    logic [CNT_W-1:0]   w_cnt_nxt [NUM_REGS];

    logic               w_iss_hit;
    logic               w_ret_hit;
    logic               w_same_rd;
    logic               w_ready;
    logic               w_iss_fire;
    logic               w_ret_zero;
    logic               w_ret_eff;
    logic               w_underflow;
    logic [NUM_SRC-1:0] w_src_busy;

    logic [NUM_REGS-1:0] r_busy;
    logic [TOT_W-1:0]    r_total;
    logic                r_underflow;

    // ------------------------------------------------------------------
    // Request qualification. Writes to x0 are never tracked.
    // ------------------------------------------------------------------
    assign w_iss_hit = sb.issue_valid & sb.issue_regf_we & (sb.issue_rd_s != C_X0);
    assign w_ret_hit = sb.retire_valid & (sb.retire_rd_s != C_X0);
    assign w_same_rd = (sb.issue_rd_s == sb.retire_rd_s);

    // Issue acceptance: a full counter still accepts when the same register
    // retires this cycle, since the retire frees the slot being claimed.
    always_comb begin
        w_ready = 1'b1;
        if (sb.flush) begin
            w_ready = 1'b0;
        end else if (w_iss_hit) begin
            w_ready = (w_cnt[sb.issue_rd_s] < C_MAX_PEND) || (w_ret_hit && w_same_rd);
        end
    end

    assign sb.issue_ready = w_ready;
    assign w_iss_fire     = w_iss_hit & w_ready;

    // Retiring register's counter is empty (index only looked at when valid).
    always_comb begin
        w_ret_zero = 1'b0;
        if (w_ret_hit) begin
            w_ret_zero = (w_cnt[sb.retire_rd_s] == '0);
        end
    end

    // A retire that cancels against a same-register issue is never an
    // underflow; otherwise a retire on an empty counter is (a writer issued
    // before a flush and retiring after it).
    assign w_underflow = ~sb.flush & w_ret_hit & w_ret_zero & ~(w_iss_fire & w_same_rd);

    // Retire contributes -1 to the total whenever it is not an underflow.
    // When it pairs with a same-register issue the +1 and -1 cancel, which
    // matches the unchanged counter.
    assign w_ret_eff = w_ret_hit & (~w_ret_zero | (w_iss_fire & w_same_rd));

    // ------------------------------------------------------------------
    // Counter array
    // ------------------------------------------------------------------
    assign w_cnt[0]     = '0;
    assign w_cnt_nxt[0] = '0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_nxt;
        logic             w_inc;
        logic             w_dec;

        assign w_inc = w_iss_fire & (sb.issue_rd_s == REG_IDX_W'(r));
        assign w_dec = w_ret_hit & (sb.retire_rd_s == REG_IDX_W'(r));

        // Next count in priority order: flush, cancel, issue, retire.
        always_comb begin
            w_nxt = r_cnt;
            if (sb.flush) begin
                w_nxt = '0;
            end else if (w_inc && w_dec) begin
                w_nxt = r_cnt;
            end else if (w_inc) begin
                w_nxt = r_cnt + CNT_W'(1);
            end else if (w_dec && (r_cnt != '0)) begin
                w_nxt = r_cnt - CNT_W'(1);
            end
        end

        // Counter storage.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_nxt;
            end
        end

        assign w_cnt[r]     = r_cnt;
        assign w_cnt_nxt[r] = w_nxt;
    end

    // ------------------------------------------------------------------
    // Source hazard query with same-cycle retire bypass. A same-cycle
    // issue is younger than the querier and does not make it busy.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        logic [REG_IDX_W-1:0] w_idx;
        logic                 w_byp;
        logic [CNT_W-1:0]     w_rem;

        assign w_idx = sb.src_s[k*REG_IDX_W +: REG_IDX_W];
        assign w_byp = w_ret_hit & (sb.retire_rd_s == w_idx);
        assign w_rem = w_cnt[w_idx] - CNT_W'(w_byp);
        assign w_src_busy[k] = (w_idx != C_X0) & (w_rem != '0);
    end

    assign sb.src_busy = w_src_busy;

    // ------------------------------------------------------------------
    // Registered status
    // ------------------------------------------------------------------

    // Busy flags track the counters that will be held after this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_busy[r] <= (w_cnt_nxt[r] != '0);
            end
        end
    end

    // Running total of all counters, kept incrementally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_total <= '0;
        end else if (sb.flush) begin
            r_total <= '0;
        end else begin
            r_total <= r_total + TOT_W'(w_iss_fire) - TOT_W'(w_ret_eff);
        end
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underflow <= 1'b0;
        end else if (w_underflow) begin
            r_underflow <= 1'b1;
        end
    end

    assign sb.busy_vec      = r_busy;
    assign sb.pending_total = r_total;
    assign sb.underflow_err = r_underflow;

endmodule
`default_nettype wire

// File: doc/regf_scoreboard.md
Name: regf_scoreboard

Overview:
Parametrised register-file scoreboard for the pipelined RV32I core. It tracks outstanding register writes per architectural register, replacing single-entry fwd_t forwarding checks once multi-cycle memory and deeper pipelines allow several in-flight writers. Decode queries it for RAW hazards and issue stalls, writeback retires entries, and branch/jump redirect flushes it.

Parameters:
NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero.
REG_IDX_W, $clog2(NUM_REGS) = 5, register index width.
MAX_PEND, 3, maximum outstanding writes per register (≥1).
NUM_SRC, 2, number of source-operand query ports.
CNT_W, $clog2(MAX_PEND+1) = 2, per-register counter width (derived).
TOT_W, $clog2(NUM_REGS*MAX_PEND+1) = 7, total-pending width (derived).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
issue_valid  in  1  instruction leaving decode this cycle
issue_regf_we  in  1  instruction writes the regfile
issue_rd_s  in  REG_IDX_W  destination register
issue_ready  out  1  issue accepted this cycle (combinational)
retire_valid  in  1  writeback retiring a regfile write
retire_rd_s  in  REG_IDX_W  retiring destination register
flush  in  1  pipeline redirect; discard all pending state
src_s  in  NUM_SRC*REG_IDX_W  packed source indices; port k at bits [k*REG_IDX_W +: REG_IDX_W]
src_busy  out  NUM_SRC  source k has an outstanding write
busy_vec  out  NUM_REGS  registered per-register busy (cnt != 0)
pending_total  out  TOT_W  registered sum of all counters
underflow_err  out  1  sticky: retire hit a zero counter

Behaviour:
- One clock domain. Reset is asynchronous and active-low. While rst_n=0: all counters 0, busy_vec=0, pending_total=0, underflow_err=0. Reset mid-operation drops all state immediately.
- State: cnt[r] (CNT_W bits) for r in 1..NUM_REGS-1. cnt[0] is constant 0.
- Terms:
  - iss_hit = issue_valid & issue_regf_we & (issue_rd_s != 0)
  - ret_hit = retire_valid & (retire_rd_s != 0)
- issue_ready (combinational):
  - 0 when flush=1.
  - Otherwise 1 when !iss_hit.
  - Otherwise 1 when cnt[issue_rd_s] < MAX_PEND, or when ret_hit with retire_rd_s == issue_rd_s (same-cycle retire frees a slot).
  - Otherwise 0. Decode must hold the instruction while issue_ready=0.
- iss_fire = iss_hit & issue_ready.
- Next-state per register r, evaluated in priority order:
  1. flush=1: cnt[r] <= 0 for all r. Issue and retire that cycle are ignored; underflow_err is not set.
  2. iss_fire and ret_hit on the same r: cnt unchanged.
  3. iss_fire on r: cnt+1. Never exceeds MAX_PEND, guaranteed by issue_ready.
  4. ret_hit on r with cnt>0: cnt-1.
  5. ret_hit on r with cnt==0: cnt stays 0 and underflow_err <= 1. This is the expected case for a writer that was issued before a flush and retires after it.
- iss_fire and ret_hit on different registers update both registers in the same cycle.
- Issue or retire to x0 has no effect, and x0 is never busy.
- src_busy[k] (combinational, with retire bypass): (cnt[src_k] - (ret_hit & retire_rd_s==src_k)) != 0, and forced 0 for src_k==0. A same-cycle issue does not set busy; the issuing instruction is younger than the querier. flush does not mask src_busy.
- busy_vec[r] is registered and equals (cnt[r] != 0) after each edge. busy_vec[0]=0.
- pending_total is registered and equals Σcnt after each edge. Implement it as an incremental ±1/0 update, or as 0 on flush. It must always equal the recomputed sum.
- underflow_err clears only on reset.
- Latency: counter updates are visible on busy_vec and pending_total 1 cycle after the edge. src_busy and issue_ready reflect current state combinationally.
- No X propagation: when their valids are low, indices may be X without affecting outputs.

Test Plan:
1. Reset, then issue rd=5 (we=1) -> next cycle busy_vec[5]=1, pending_total=1. With src_s={x,5} -> src_busy[0]=1. Retire rd=5 -> src_busy[0]=0 that same cycle, and busy_vec[5]=0 next cycle.
2. Issue rd=7 three times (MAX_PEND=3) -> cnt=3, pending_total=3. A 4th issue to rd=7 -> issue_ready=0 and no change. The 4th issue plus retire rd=7 in the same cycle -> issue_ready=1, and cnt stays 3.
3. Issue rd=0 with we=1, and issue rd=4 with we=0 -> issue_ready=1, busy_vec=0, pending_total=0. Query src=0 -> src_busy=0.
4. Pending rd=3 (cnt 2) and rd=9 (cnt 1), then flush together with issue rd=3 -> issue_ready=0. Next cycle all busy_vec=0, pending_total=0. A later retire rd=3 -> underflow_err=1 and it stays 1.
5. Issue rd=10 and retire rd=12 (cnt 1) in the same cycle -> cnt[10]=1, cnt[12]=0, pending_total unchanged.
6. Assert rst_n=0 asynchronously mid-stream with 5 registers pending -> outputs clear before the next clk edge. After release, issue_ready=1.
